// File: rtl/ram_master.sv
// ram_master: initiator-side burst controller for a 256x8 single-port sync RAM
// with a one-cycle registered read.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           burst request handshake (accepted in IDLE)
//   req_wr, req_addr, req_len     burst direction, start address, beats-1
//   wd_valid/wd_ready, wd_data    write-data beats
//   rd_valid, rd_data, rd_last    read beats (data straight from mem_dout)
//   done                          one-cycle pulse at burst completion
//   mem_en, mem_wr, mem_addr,
//   mem_din, mem_dout             RAM pins
module ram_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] beats_left_q, beats_left_d;
  logic              rd_pend_q, rd_pend_d;
  logic              last_pend_q, last_pend_d;
  logic              done_q, done_d;
  logic              wr_fire;

  // A write beat is issued in the same cycle wd_valid is seen in WRITE.
  assign wr_fire = (state_q == S_WRITE) && wd_valid;

  // Next-state and register update logic.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_pend_d    = 1'b0;
    last_pend_d  = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (wd_valid) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (beats_left_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            beats_left_d = beats_left_q - ADDR_W'(1);
          end
        end
      end
      S_READ: begin
        // Every READ cycle issues a beat; its data returns next cycle.
        rd_pend_d    = 1'b1;
        cur_addr_d   = cur_addr_q + ADDR_W'(1);
        beats_left_d = beats_left_q - ADDR_W'(1);
        if (beats_left_q == '0) begin
          last_pend_d = 1'b1;
          done_d      = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_pend_q    <= 1'b0;
      last_pend_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_pend_q    <= rd_pend_d;
      last_pend_q  <= last_pend_d;
      done_q       <= done_d;
    end
  end

  // RAM strobes follow wd_valid in the same cycle so writes need no extra latency.
  assign req_ready = (state_q == S_IDLE);
  assign wd_ready  = (state_q == S_WRITE);
  assign mem_en    = wr_fire || (state_q == S_READ);
  assign mem_wr    = wr_fire;
  assign mem_addr  = cur_addr_q;
  assign mem_din   = wr_fire ? wd_data : '0;
  assign rd_valid  = rd_pend_q;
  assign rd_last   = last_pend_q;
  assign rd_data   = mem_dout;
  assign done      = done_q;

endmodule

// File: doc/ram_master.md
# ram_master

Initiator-side controller for the single-port synchronous RAM (`ram_sync`, 256 x 8, one-cycle registered read). It accepts read or write burst requests over a valid/ready handshake, sequences `en`/`wr`/`addr`/`data_in` toward the RAM beat by beat with address auto-increment, and returns read data with a valid strobe. It sits between the datapath or test sequencer and the RAM, so no other logic drives RAM control pins directly.

## Interface
- `ADDR_W`, default 8: RAM address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, default 8: RAM data width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request (IDLE only).
- `req_wr`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  ADDR_W  start address.
- `req_len`  in  ADDR_W  beats minus one (0 = 1 beat, 255 = 256 beats).
- `wd_valid`  in  1  write-data beat present.
- `wd_ready`  out  1  write beat accepted this cycle.
- `wd_data`  in  DATA_W  write-data beat.
- `rd_valid`  out  1  `rd_data` valid this cycle.
- `rd_data`  out  DATA_W  read beat (direct from `mem_dout`).
- `rd_last`  out  1  final beat of a read burst, qualified by `rd_valid`.
- `done`  out  1  one-cycle pulse when a burst completes.
- `mem_en`, `mem_wr`  out  1  RAM `en`, `wr`.
- `mem_addr`  out  ADDR_W  RAM `addr`.
- `mem_din`  out  DATA_W  RAM `data_in`.
- `mem_dout`  in  DATA_W  RAM `data_out`.

## Operation
- States: IDLE, WRITE, READ, DRAIN. Registers: `state`, `cur_addr`, `beats_left`, `rd_pend`, `last_pend`.
- IDLE: `req_ready`=1. When `req_valid`=1 at a clock edge, the edge latches `cur_addr`=`req_addr` and `beats_left`=`req_len`. The next state is WRITE if `req_wr`=1, otherwise READ.
- WRITE: `wd_ready`=1. In any cycle with `wd_valid`=1, drive `mem_en`=1, `mem_wr`=1, `mem_addr`=`cur_addr`, `mem_din`=`wd_data`. On that edge, `cur_addr` increments by 1. If `beats_left`=0, the edge instead moves to IDLE and pulses `done` in the following cycle; otherwise it decrements `beats_left`. While `wd_valid`=0, the controller waits with `mem_en`=0, and the address does not advance.
- READ: every cycle, drive `mem_en`=1, `mem_wr`=0, `mem_addr`=`cur_addr`. The edge sets `rd_pend`=1, increments `cur_addr`, and decrements `beats_left`. The beat issued with `beats_left`=0 sets `last_pend`=1 and moves to DRAIN. There is no read backpressure.
- DRAIN: `mem_en`=0. `rd_valid`=1 with `rd_last`=1 for the final beat. `done`=1. The next edge moves to IDLE.
- `rd_valid`=`rd_pend`, `rd_last`=`last_pend`, `rd_data`=`mem_dout`.
- Outside WRITE/READ issue cycles: `mem_en`=0, `mem_wr`=0, `mem_addr`=`cur_addr`, `mem_din`=0.
- Address wrap: 255 + 1 -> 0, with no error. A 256-beat burst touches every address exactly once.
- `req_valid` is ignored outside IDLE. Request fields are sampled only at acceptance, so they may change afterwards.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): `state`=IDLE, `cur_addr`=0, `beats_left`=0, `rd_pend`=0, `last_pend`=0. Outputs become `req_ready`=1, `wd_ready`=0, `rd_valid`=0, `rd_last`=0, `done`=0, `mem_en`=0, `mem_wr`=0, `mem_addr`=0, `mem_din`=0.
- Reset mid-burst aborts immediately. No further RAM access occurs, and pending read beats are discarded with `rd_valid`=0.
- Read burst of N beats, accepted at edge E0: RAM issue occurs in cycles 1..N after E0. `rd_valid` is high in cycles 2..N+1, so the data for `req_addr`+k appears in cycle k+2. `done` and `rd_last` are high in cycle N+1. `req_ready` returns in cycle N+2.
- Write burst of N beats with `wd_valid` held high: RAM writes occur in cycles 1..N. `done` is in cycle N+1 with `req_ready`=1. The next request can be accepted at the end of cycle N+1.
- Read latency is fixed at one cycle from issue to `rd_valid`.
- `done` never coincides with `req_ready`=0 in IDLE.

## Test plan
- Reset, then write 1 beat (addr 5, data 25) -> a single `mem_en`=`mem_wr`=1 cycle with `mem_addr`=5, `mem_din`=25, then `done`. Next, write (20, 150) the same way.
- Read 1 beat at addr 5 -> `mem_en`=1, `mem_wr`=0 in cycle 1. In cycle 2, `rd_valid`=`rd_last`=`done`=1 with `rd_data`=25. `req_ready`=1 in cycle 3.
- Write a 4-beat burst at 254 with data 77, 78, 79, 80, toggling `wd_valid` 1,0,1,1,1 -> writes to 254, 255, 0, 1 (wrap). `mem_en`=0 in the gap cycle. Reading 4 beats at 254 returns 77, 78, 79, 80 on consecutive cycles, with `rd_last` on 80.
- Pulse `req_valid` during a read burst with different fields -> it is ignored. The burst completes unchanged, and the request is accepted only once `req_ready`=1.
- Assert `rst_n`=0 in the middle of an 8-beat read at 20 -> `mem_en`=0 and `rd_valid`=0 immediately, with no `done`. After release, `req_ready`=1 and a read at 20 returns 150.
- Write 256 beats with data = address starting at 0, then read 256 at 128 -> `rd_data` sequence 128..255, 0..127, `rd_last` only on the final beat (127).
